// File: rtl/j_deserializer_writer.sv
// Receive end of the bit-serial pixel link: rebuilds LSB-first bytes from serial_in/serial_en
// and writes them as {skip, data} words to consecutive activation-SRAM addresses, one frame per start.
//
// state     | meaning
// S_IDLE    | waiting for write_start; serial strobes here flag proto_err
// S_COLLECT | assembling bytes and issuing one SRAM write per completed byte
// S_DONE    | last write (with write_done) on the outputs; returns to idle next cycle
module j_deserializer_writer #(
    parameter int SRAM_DEPTH  = 256 * 256 * 4,
    parameter int SRAM_ADDR_W = $clog2(SRAM_DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   write_start,
    output logic                   write_idle,
    output logic                   write_done,
    input  logic [SRAM_ADDR_W-1:0] start_addr,
    input  logic [SRAM_ADDR_W-1:0] img_width_size,
    input  logic [SRAM_ADDR_W-1:0] img_height_size,
    input  logic                   serial_in,
    input  logic                   serial_en,
    output logic                   sram_we,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [8:0]             sram_wdata,
    output logic                   proto_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic [SRAM_ADDR_W-1:0] ADDR_ONE = {{(SRAM_ADDR_W-1){1'b0}}, 1'b1};

    state_t                   state_q;
    logic                     write_idle_q;
    logic                     write_done_q;
    logic                     sram_we_q;
    logic [SRAM_ADDR_W-1:0]   sram_addr_q;
    logic [8:0]               sram_wdata_q;
    logic                     proto_err_q;
    logic [2:0]               bit_cnt_q;
    logic [7:0]               shift_q;
    logic [SRAM_ADDR_W-1:0]   w_cnt_q;
    logic [SRAM_ADDR_W-1:0]   h_cnt_q;
    logic [SRAM_ADDR_W-1:0]   width_q;
    logic [SRAM_ADDR_W-1:0]   height_q;
    logic [SRAM_ADDR_W-1:0]   pix_addr_q;
    logic [7:0]               byte_d;

    // The completing bit is merged directly so the write can issue the very next cycle.
    assign byte_d = {serial_in, shift_q[6:0]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            write_idle_q <= 1'b1;
            write_done_q <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            proto_err_q  <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            w_cnt_q      <= '0;
            h_cnt_q      <= '0;
            width_q      <= '0;
            height_q     <= '0;
            pix_addr_q   <= '0;
        end else begin
            sram_we_q    <= 1'b0;
            write_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (write_start) begin
                        state_q      <= S_COLLECT;
                        write_idle_q <= 1'b0;
                        pix_addr_q   <= start_addr;
                        width_q      <= img_width_size;
                        height_q     <= img_height_size;
                        bit_cnt_q    <= '0;
                        w_cnt_q      <= '0;
                        h_cnt_q      <= '0;
                        proto_err_q  <= 1'b0;
                    end else if (serial_en) begin
                        proto_err_q <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (serial_en) begin
                        shift_q[bit_cnt_q] <= serial_in;
                        bit_cnt_q          <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            sram_we_q    <= 1'b1;
                            sram_addr_q  <= pix_addr_q;
                            sram_wdata_q <= {(byte_d == 8'h00), byte_d};
                            pix_addr_q   <= pix_addr_q + ADDR_ONE;
                            if (w_cnt_q == width_q) begin
                                w_cnt_q <= '0;
                                if (h_cnt_q == height_q) begin
                                    write_done_q <= 1'b1;
                                    state_q      <= S_DONE;
                                end else begin
                                    h_cnt_q <= h_cnt_q + ADDR_ONE;
                                end
                            end else begin
                                w_cnt_q <= w_cnt_q + ADDR_ONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (serial_en) begin
                        proto_err_q <= 1'b1;
                    end
                    state_q      <= S_IDLE;
                    write_idle_q <= 1'b1;
                end
                default: begin
                    state_q      <= S_IDLE;
                    write_idle_q <= 1'b1;
                end
            endcase
        end
    end

    assign write_idle = write_idle_q;
    assign write_done = write_done_q;
    assign sram_we    = sram_we_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_j_deserializer_writer.sv
// Scoreboard bench for j_deserializer_writer: the stimulus side queues the SRAM writes each frame
// must produce (address, {skip,data}, done flag, cycle); a negedge monitor pops and compares.
module tb_j_deserializer_writer;

    localparam int AW = 18;
    localparam logic [AW-1:0] AMAX = '1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          write_start;
    logic          write_idle;
    logic          write_done;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] img_width_size;
    logic [AW-1:0] img_height_size;
    logic          serial_in;
    logic          serial_en;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [8:0]    sram_wdata;
    logic          proto_err;

    j_deserializer_writer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .write_start     (write_start),
        .write_idle      (write_idle),
        .write_done      (write_done),
        .start_addr      (start_addr),
        .img_width_size  (img_width_size),
        .img_height_size (img_height_size),
        .serial_in       (serial_in),
        .serial_en       (serial_en),
        .sram_we         (sram_we),
        .sram_addr       (sram_addr),
        .sram_wdata      (sram_wdata),
        .proto_err       (proto_err)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [8:0]    data;
        logic          last;
        int            cyc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] byte_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic       expect_idle = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every SRAM write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (expect_idle) begin
            chk("idle_after_done", 32'(write_idle), 32'd1);
            expect_idle = 1'b0;
        end
        if (reset_n && sram_we) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h, no write expected", sram_addr, sram_wdata);
            end else begin
                e = sb.pop_front();
                chk("write_addr", 32'(sram_addr), 32'(e.addr));
                chk("write_data", 32'(sram_wdata), 32'(e.data));
                chk("write_done_flag", 32'(write_done), 32'(e.last));
                chk("write_latency_cycle", 32'(cyc), 32'(e.cyc));
                if (e.last) expect_idle = 1'b1;
            end
        end else if (reset_n && write_done) begin
            checks++;
            errors++;
            $display("FAIL done_without_write: write_done=1 while sram_we=0");
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gmax, input logic [AW-1:0] addr,
                             input logic last);
        for (int i = 0; i < 8; i++) begin
            int g;
            g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
            repeat (g) begin
                serial_en = 1'b0;
                @(negedge clk);
            end
            serial_en = 1'b1;
            serial_in = b[i];
            if (i == 7) begin
                exp_t e;
                e.addr = addr;
                e.data = {(b == 8'h00), b};
                e.last = last;
                e.cyc  = cyc + 1;
                sb.push_back(e);
            end
            @(negedge clk);
        end
    endtask

    // Runs one frame; byte_q supplies directed pixels, otherwise they are random.
    // poke_at >= 0 pulses write_start (with other settings) before that pixel.
    task automatic run_frame(input logic [AW-1:0] addr, input int w, input int h,
                             input int gmax, input int poke_at);
        int npix;
        int k;
        npix = (w + 1) * (h + 1);
        if (byte_q.size() == 0) begin
            for (int p = 0; p < npix; p++) begin
                if ($urandom_range(3, 0) == 0) byte_q.push_back(8'h00);
                else byte_q.push_back(8'($urandom));
            end
        end
        start_addr      = addr;
        img_width_size  = AW'(w);
        img_height_size = AW'(h);
        write_start     = 1'b1;
        @(negedge clk);
        write_start     = 1'b0;
        chk("start_leaves_idle", 32'(write_idle), 32'd0);
        chk("start_clears_proto_err", 32'(proto_err), 32'd0);
        start_addr      = AW'($urandom);
        img_width_size  = AW'($urandom_range(7, 0));
        img_height_size = AW'($urandom_range(7, 0));
        for (int p = 0; p < npix; p++) begin
            if (p == poke_at) begin
                serial_en   = 1'b0;
                write_start = 1'b1;
                @(negedge clk);
                write_start = 1'b0;
            end
            send_byte(byte_q[p], gmax, addr + p[AW-1:0], p == npix - 1);
        end
        serial_en = 1'b0;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL write_timeout: %0d writes outstanding, expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
        chk("frame_end_idle", 32'(write_idle), 32'd1);
        chk("frame_end_no_proto_err", 32'(proto_err), 32'd0);
        byte_q.delete();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_sram_we", 32'(sram_we), 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_sram_wdata", 32'(sram_wdata), 32'd0);
        chk("rst_write_done", 32'(write_done), 32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        chk("rst_write_idle", 32'(write_idle), 32'd1);
    endtask

    initial begin
        logic [7:0] pb;
        reset_n         = 1'b0;
        write_start     = 1'b0;
        start_addr      = '0;
        img_width_size  = '0;
        img_height_size = '0;
        serial_in       = 1'b0;
        serial_en       = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        reset_n = 1'b1;
        @(negedge clk);

        // 2x2 frame, back-to-back bytes including a skip pixel
        byte_q = '{8'h5A, 8'h00, 8'hFF, 8'h81};
        run_frame(18'h10, 1, 1, 0, -1);

        // 3x1 frame with gapped strobes
        byte_q = '{8'h01, 8'h80, 8'h7E};
        run_frame(18'h200, 2, 0, 3, -1);

        // strobes while idle raise a sticky protocol error, no writes
        repeat (5) begin
            serial_en = 1'b1;
            serial_in = 1'($urandom);
            @(negedge clk);
        end
        serial_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_strobe_proto_err", 32'(proto_err), 32'd1);
        chk("idle_strobe_still_idle", 32'(write_idle), 32'd1);
        run_frame(18'h3_0000, 1, 2, 2, -1);

        // reset in the middle of a byte discards it
        start_addr      = 18'h300;
        img_width_size  = 18'd1;
        img_height_size = 18'd0;
        write_start     = 1'b1;
        @(negedge clk);
        write_start = 1'b0;
        pb = 8'hE7;
        for (int i = 0; i < 5; i++) begin
            serial_en = 1'b1;
            serial_in = pb[i];
            @(negedge clk);
        end
        serial_en = 1'b0;
        reset_n   = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk_reset_outputs();
        @(negedge clk);
        byte_q = '{8'hC3, 8'h18};
        run_frame(18'h300, 1, 0, 1, -1);

        // write_start mid-frame is ignored
        run_frame(18'h1000, 2, 1, 1, 2);

        // single pixel at the top address, then frames wrapping to address 0
        byte_q = '{8'h3C};
        run_frame(AMAX, 0, 0, 0, -1);
        run_frame(AMAX, 1, 0, 1, -1);
        run_frame(AMAX, 0, 1, 2, -1);

        for (int f = 0; f < 8; f++) begin
            logic [AW-1:0] a;
            int w;
            int h;
            a = ($urandom_range(1, 0) == 1) ? AMAX - AW'($urandom_range(3, 0)) : AW'($urandom);
            w = int'($urandom_range(3, 0));
            h = int'($urandom_range(3, 0));
            run_frame(a, w, h, int'($urandom_range(3, 0)),
                      ($urandom_range(2, 0) == 0) ? int'($urandom_range((w + 1) * (h + 1) - 1, 0)) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
